spi_master_byte: RTL and testbench
==================================

Name: spi_master_byte

Overview:
- Byte-oriented SPI master (mode 0, MSB first) that generates cs, sclk and mosi for the team's SPI slave shift register and captures miso.
- Sits upstream of the slave, on the system clock domain.
- Takes one byte via a valid/ready handshake, runs one cs-framed transfer and returns the received byte as a one-cycle rx_valid pulse.
- sclk is derived from clk by a programmable divider.

Parameters:
- DATA_W, 8, bits per transfer (frame length).
- CLK_DIV, 2, clk cycles per sclk half-period; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_W  byte to transmit; sampled on accept.
- tx_valid  input  1  request a transfer.
- tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready at a clk edge.
- rx_data  output  DATA_W  byte captured from miso; held until the next rx_valid.
- rx_valid  output  1  one-cycle pulse when rx_data updates; no backpressure.
- cs  output  1  slave select, active low.
- sclk  output  1  SPI clock, idle low, registered.
- mosi  output  1  serial data to slave, registered.
- miso  input  1  serial data from slave.

Behaviour:
- Reset values (asynchronous, immediate): cs=1, sclk=0, mosi=0, tx_ready=1, rx_valid=0, rx_data=0.
- Reset internals: state=IDLE, shift registers=0, counters=0.
- Divider: div_cnt counts 0..CLK_DIV-1 in every non-IDLE state. The phase ends on the edge where div_cnt==CLK_DIV-1, then div_cnt is cleared.
- IDLE:
  - Outputs: cs=1, sclk=0, tx_ready=1.
  - On accept: latch tx_data into tx_sh, set cs<=0, mosi<=tx_data[DATA_W-1], bit_cnt<=0, tx_ready<=0, go to LEAD.
- LEAD: at phase end, sclk<=1, rx_sh<={rx_sh[DATA_W-2:0], miso}, go to HIGH.
- HIGH:
  - At phase end, sclk<=0.
  - If bit_cnt==DATA_W-1, go to TRAIL.
  - Otherwise bit_cnt++, tx_sh<<=1, mosi<=next bit (tx_sh[DATA_W-2]), go to LOW.
- LOW: at phase end, sclk<=1, shift miso into rx_sh, go to HIGH.
- TRAIL: at phase end, cs<=1, rx_data<=rx_sh, rx_valid<=1 for one cycle, go to GAP.
- GAP: at phase end, tx_ready<=1, go to IDLE.
- Bit alignment:
  - miso is sampled at the same clk edge where sclk is registered 0→1, i.e. the value present before the slave's rising edge.
  - mosi changes only with sclk falling (or cs falling for bit DATA_W-1), so it is stable across every rising edge.
- Frame shape: exactly DATA_W rising sclk edges per frame; sclk is low whenever cs toggles.
- Latency:
  - rx_valid is asserted 17*CLK_DIV clk cycles after the accept edge (DATA_W=8; in general (2*DATA_W+1)*CLK_DIV).
  - tx_ready returns CLK_DIV cycles after rx_valid.
  - Minimum cs-high time between frames is CLK_DIV+1 cycles.
- tx_valid while busy is ignored; tx_data is not re-sampled mid-frame.
- Reset mid-transfer aborts the frame: cs rises immediately and no rx_valid is produced.
- miso is treated as synchronous to clk (slave is clocked by our sclk); no synchronizer.

Decomposition:
- spi_pkg holds:
  - State encoding localparams: ST_IDLE, ST_LEAD, ST_HIGH, ST_LOW, ST_TRAIL, ST_GAP (3-bit).
  - Default DATA_W and CLK_DIV.
- Optional sub-module spi_half_period_cnt: div_cnt with clear, emits a phase_end strobe.
- The FSM and both shift registers stay in spi_master_byte.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> cs=1, sclk=0, mosi=0, tx_ready=1, rx_valid=0 immediately; after release there is no activity with tx_valid=0.
- TX path: CLK_DIV=2, send 0xA5; bench slave samples mosi on sclk rise -> captures 0xA5, exactly 8 rising edges, rx_valid 34 cycles after accept, tx_ready high 2 cycles later.
- RX path: bench slave drives 0x3C MSB-first (bit 7 at cs fall, next bit on each sclk fall) -> rx_data=0x3C with a single-cycle rx_valid.
- Back-to-back: tx_valid held high with 0x01 then 0xFF -> two frames, cs high exactly CLK_DIV+1=3 cycles between them, mosi patterns 0x01 and 0xFF; tx_data changes while busy are ignored.
- Abort: rst_n low after the 3rd sclk rise -> cs=1 and sclk=0 asynchronously, no rx_valid; the next transfer of 0x5A completes correctly.
- Corner: CLK_DIV=1, patterns 0x00 and 0xFF, plus loopback mosi->miso -> rx_data equals tx_data; sclk period is 2 clk cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the byte-oriented SPI master.
package spi_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

endpackage

// File: rtl/spi_master_byte_if.sv
// Byte handshake plus SPI pins between the SPI master and its surroundings.
interface spi_master_byte_if #(
  parameter int DATA_W = spi_pkg::DEF_DATA_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic              miso;

  modport master (
    input  tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, cs, sclk, mosi
  );

  modport slave (
    output tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, cs, sclk, mosi
  );

endinterface

// File: rtl/spi_half_period_cnt.sv
// sclk half-period divider: counts while enabled, strobes on the last clk of a phase.
module spi_half_period_cnt #(
  parameter int CLK_DIV = spi_pkg::DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_phase_end
);

  logic [7:0] r_div_cnt;

  always_comb begin
    o_phase_end = i_en && (r_div_cnt == 8'(CLK_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (!i_en || o_phase_end) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_byte.sv
// Mode-0, MSB-first SPI master: one byte per cs-framed transfer via valid/ready.
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_byte_if.master  bus
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_tx_sh, w_tx_sh_nxt;
  logic [DATA_W-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic [BCW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic              r_cs, w_cs_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_mosi, w_mosi_nxt;
  logic              r_tx_ready, w_tx_ready_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              w_busy;
  logic              w_phase_end;
  logic              w_accept;

  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_accept = bus.tx_valid && r_tx_ready;
  end

  spi_half_period_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_busy),
    .o_phase_end (w_phase_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_tx_ready <= 1'b1;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_cs       <= w_cs_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

  // miso is captured on the same clk edge that raises sclk, so the value seen
  // is the one the slave presented before its rising edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_sh_nxt    = r_tx_sh;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_data_nxt  = r_rx_data;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_cs_nxt       = r_cs;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_tx_ready_nxt = r_tx_ready;
    w_rx_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cs_nxt   = 1'b1;
        w_sclk_nxt = 1'b0;
        if (w_accept) begin
          w_tx_sh_nxt    = bus.tx_data;
          w_cs_nxt       = 1'b0;
          w_mosi_nxt     = bus.tx_data[DATA_W-1];
          w_bit_cnt_nxt  = '0;
          w_tx_ready_nxt = 1'b0;
          w_state_nxt    = ST_LEAD;
        end
      end
      ST_LEAD, ST_LOW: begin
        if (w_phase_end) begin
          w_sclk_nxt  = 1'b1;
          w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], bus.miso};
          w_state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_phase_end) begin
          w_sclk_nxt = 1'b0;
          if (r_bit_cnt == BCW'(DATA_W - 1)) begin
            w_state_nxt = ST_TRAIL;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
            w_tx_sh_nxt   = r_tx_sh << 1;
            w_mosi_nxt    = r_tx_sh[DATA_W-2];
            w_state_nxt   = ST_LOW;
          end
        end
      end
      ST_TRAIL: begin
        if (w_phase_end) begin
          w_cs_nxt       = 1'b1;
          w_rx_data_nxt  = r_rx_sh;
          w_rx_valid_nxt = 1'b1;
          w_state_nxt    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_phase_end) begin
          w_tx_ready_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.tx_ready = r_tx_ready;
    bus.rx_data  = r_rx_data;
    bus.rx_valid = r_rx_valid;
    bus.cs       = r_cs;
    bus.sclk     = r_sclk;
    bus.mosi     = r_mosi;
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte: behavioural slaves, scoreboard queues, CLK_DIV=2 and 1.
module tb_spi_master_byte;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_master_byte_if #(.DATA_W(8)) bus_a ();
  spi_master_byte_if #(.DATA_W(8)) bus_b ();

  spi_master_byte #(.DATA_W(8), .CLK_DIV(2)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
  );

  spi_master_byte #(.DATA_W(8), .CLK_DIV(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] qa_rx[$];
  logic [7:0] qa_tx[$];
  logic [7:0] qb_rx[$];
  logic [7:0] qb_tx[$];

  int a_acc_cnt = 0, b_acc_cnt = 0;
  int a_acc_cyc = 0, b_acc_cyc = 0;
  int a_rxv_cyc = 0, b_rxv_cyc = 0;
  int a_rxv_cnt = 0, b_rxv_cnt = 0;
  bit a_rxv_seen = 0, b_rxv_seen = 0;
  logic a_prev_rxv = 0, a_prev_rdy = 0, a_prev_cs = 1;
  logic b_prev_rxv = 0, b_prev_rdy = 0, b_prev_cs = 1, b_prev_sclk = 0;
  int a_cs_rise_cyc = 0, a_gap = 0, b_last_rise = 0;

  // bench slaves: A shifts a_slv_tx out on miso, B loops mosi back to miso
  logic [7:0] a_slv_tx = 8'h00;
  logic [7:0] a_sh = 8'h00;
  logic [7:0] a_cap = 8'h00, b_cap = 8'h00;
  int a_rise = 0, b_rise = 0;
  logic a_pcs = 1'b1, a_psclk = 1'b0, b_pcs = 1'b1, b_psclk = 1'b0;

  assign bus_a.miso = a_sh[7];
  assign bus_b.miso = bus_b.mosi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string t, input logic cs, input logic sclk, input logic mosi,
                         input logic rdy, input logic rxv, input logic [7:0] rxd);
    chk({t, "_cs"}, cs, 1);
    chk({t, "_sclk"}, sclk, 0);
    chk({t, "_mosi"}, mosi, 0);
    chk({t, "_tx_ready"}, rdy, 1);
    chk({t, "_rx_valid"}, rxv, 0);
    chk({t, "_rx_data"}, rxd, 0);
  endtask

  always @(bus_a.cs or bus_a.sclk) begin
    if (a_pcs === 1'b1 && bus_a.cs === 1'b0) begin
      a_sh = a_slv_tx; a_rise = 0; a_cap = 0;
    end else if (bus_a.cs === 1'b0 && a_psclk === 1'b0 && bus_a.sclk === 1'b1) begin
      a_cap = {a_cap[6:0], bus_a.mosi}; a_rise++;
    end else if (bus_a.cs === 1'b0 && a_psclk === 1'b1 && bus_a.sclk === 1'b0) begin
      a_sh = a_sh << 1;
    end
    a_pcs = bus_a.cs; a_psclk = bus_a.sclk;
  end

  always @(bus_b.cs or bus_b.sclk) begin
    if (b_pcs === 1'b1 && bus_b.cs === 1'b0) begin
      b_rise = 0; b_cap = 0;
    end else if (bus_b.cs === 1'b0 && b_psclk === 1'b0 && bus_b.sclk === 1'b1) begin
      b_cap = {b_cap[6:0], bus_b.mosi}; b_rise++;
    end
    b_pcs = bus_b.cs; b_psclk = bus_b.sclk;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus_a.tx_valid && bus_a.tx_ready) begin a_acc_cnt++; a_acc_cyc = cyc; end
    if (rst_n && bus_b.tx_valid && bus_b.tx_ready) begin b_acc_cnt++; b_acc_cyc = cyc; end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.rx_valid) begin
        a_rxv_cnt++;
        chk("a_rxv_single", a_prev_rxv, 0);
        chk("a_rxv_expected", qa_rx.size() != 0, 1);
        if (qa_rx.size() != 0) chk("a_rx_data", bus_a.rx_data, qa_rx.pop_front());
        chk("a_latency", cyc - a_acc_cyc, 34);
        a_rxv_cyc = cyc; a_rxv_seen = 1;
      end
      if (bus_a.tx_ready && !a_prev_rdy && a_rxv_seen) begin
        chk("a_ready_return", cyc - a_rxv_cyc, 2);
        a_rxv_seen = 0;
      end
      if (bus_a.cs && !a_prev_cs) begin
        a_cs_rise_cyc = cyc;
        if (qa_tx.size() != 0) begin
          chk("a_mosi_byte", a_cap, qa_tx.pop_front());
          chk("a_sclk_rises", a_rise, 8);
        end
      end
      if (!bus_a.cs && a_prev_cs) a_gap = cyc - a_cs_rise_cyc;
    end
    a_prev_rxv = bus_a.rx_valid; a_prev_rdy = bus_a.tx_ready; a_prev_cs = bus_a.cs;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.rx_valid) begin
        b_rxv_cnt++;
        chk("b_rxv_single", b_prev_rxv, 0);
        chk("b_rxv_expected", qb_rx.size() != 0, 1);
        if (qb_rx.size() != 0) chk("b_rx_data", bus_b.rx_data, qb_rx.pop_front());
        chk("b_latency", cyc - b_acc_cyc, 17);
        b_rxv_cyc = cyc; b_rxv_seen = 1;
      end
      if (bus_b.tx_ready && !b_prev_rdy && b_rxv_seen) begin
        chk("b_ready_return", cyc - b_rxv_cyc, 1);
        b_rxv_seen = 0;
      end
      if (!bus_b.cs && b_prev_cs) b_last_rise = 0;
      if (bus_b.sclk && !b_prev_sclk) begin
        if (b_last_rise != 0) chk("b_sclk_period", cyc - b_last_rise, 2);
        b_last_rise = cyc;
      end
      if (bus_b.cs && !b_prev_cs && qb_tx.size() != 0) begin
        chk("b_mosi_byte", b_cap, qb_tx.pop_front());
        chk("b_sclk_rises", b_rise, 8);
      end
    end
    b_prev_rxv = bus_b.rx_valid; b_prev_rdy = bus_b.tx_ready;
    b_prev_cs = bus_b.cs; b_prev_sclk = bus_b.sclk;
  end

  task automatic send_a(input logic [7:0] d, input logic [7:0] slv, input bit hold, input bit keep);
    int n;
    n = a_acc_cnt;
    @(negedge clk);
    a_slv_tx = slv; bus_a.tx_data = d; bus_a.tx_valid = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (a_acc_cnt != n) break;
    end
    chk("a_accept", a_acc_cnt - n, 1);
    if (!hold) bus_a.tx_valid = 1'b0;
    if (keep) begin qa_tx.push_back(d); qa_rx.push_back(slv); end
  endtask

  task automatic send_b(input logic [7:0] d);
    int n;
    n = b_acc_cnt;
    @(negedge clk);
    bus_b.tx_data = d; bus_b.tx_valid = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (b_acc_cnt != n) break;
    end
    chk("b_accept", b_acc_cnt - n, 1);
    bus_b.tx_valid = 1'b0;
    qb_tx.push_back(d); qb_rx.push_back(d);
  endtask

  task automatic wait_idle_a();
    repeat (300) begin
      @(negedge clk);
      if (bus_a.tx_ready === 1'b1) break;
    end
    chk("a_idle", bus_a.tx_ready, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle_b();
    repeat (300) begin
      @(negedge clk);
      if (bus_b.tx_ready === 1'b1) break;
    end
    chk("b_idle", bus_b.tx_ready, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus_a.tx_valid = 1'b0; bus_a.tx_data = 8'h00;
    bus_b.tx_valid = 1'b0; bus_b.tx_data = 8'h00;

    // reset asserted between clock edges takes effect immediately
    #3 rst_n = 1'b0;
    #1;
    chk_rst("rst_a", bus_a.cs, bus_a.sclk, bus_a.mosi, bus_a.tx_ready, bus_a.rx_valid, bus_a.rx_data);
    chk_rst("rst_b", bus_b.cs, bus_b.sclk, bus_b.mosi, bus_b.tx_ready, bus_b.rx_valid, bus_b.rx_data);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_accept", a_acc_cnt + b_acc_cnt, 0);
    chk("idle_a_cs", bus_a.cs, 1);
    chk("idle_a_sclk", bus_a.sclk, 0);

    // TX path, then RX path
    send_a(8'hA5, 8'h00, 0, 1); wait_idle_a();
    send_a(8'h96, 8'h3C, 0, 1); wait_idle_a();

    // back-to-back with tx_valid held and tx_data changing while busy
    send_a(8'h01, 8'hC6, 1, 1);
    send_a(8'hFF, 8'h81, 1, 1);
    bus_a.tx_data = 8'h77;
    n = a_acc_cnt;
    repeat (10) @(negedge clk);
    chk("a_busy_ignored", a_acc_cnt, n);
    bus_a.tx_valid = 1'b0;
    wait_idle_a();
    chk("a_cs_gap", a_gap, 3);

    // abort after the third sclk rise
    send_a(8'hC3, 8'h55, 0, 0);
    repeat (200) begin
      @(negedge clk);
      if (a_rise >= 3) break;
    end
    chk("abort_rise", a_rise, 3);
    #2 rst_n = 1'b0;
    #1;
    chk_rst("abort_a", bus_a.cs, bus_a.sclk, bus_a.mosi, bus_a.tx_ready, bus_a.rx_valid, bus_a.rx_data);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_a(8'h5A, 8'hE7, 0, 1); wait_idle_a();

    // CLK_DIV=1 with loopback
    send_b(8'h00); wait_idle_b();
    send_b(8'hFF); wait_idle_b();
    send_b(8'h6D); wait_idle_b();

    repeat (5) @(negedge clk);
    chk("a_rx_q_empty", qa_rx.size(), 0);
    chk("a_tx_q_empty", qa_tx.size(), 0);
    chk("b_rx_q_empty", qb_rx.size(), 0);
    chk("b_tx_q_empty", qb_tx.size(), 0);
    chk("a_rxv_count", a_rxv_cnt, 5);
    chk("b_rxv_count", b_rxv_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
